// File: rtl/instruction_fetch_if.sv
// Program-memory read port and decoded-bundle handoff between the fetch unit
// and its neighbours (memory, execute redirect, decoder).
interface instruction_fetch_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        take;
    logic        bundle_valid;
    logic [15:0] ir;
    logic [15:0] src_ext;
    logic [15:0] dst_ext;
    logic        has_src_ext;
    logic        has_dst_ext;
    logic [15:0] inst_pc;
    logic [15:0] next_pc;

    modport master (
        output mem_rd, mem_addr, bundle_valid, ir, src_ext, dst_ext,
               has_src_ext, has_dst_ext, inst_pc, next_pc,
        input  mem_rdata, mem_ready, pc_load, pc_new, take
    );

    modport slave (
        input  mem_rd, mem_addr, bundle_valid, ir, src_ext, dst_ext,
               has_src_ext, has_dst_ext, inst_pc, next_pc,
        output mem_rdata, mem_ready, pc_load, pc_new, take
    );
endinterface

// File: rtl/instruction_fetch.sv
// MSP430 instruction fetch: loads the reset vector, then gathers opcode plus
// extension words into one bundle for the decoder.
//
// state      | meaning
// VECTOR     | read RESET_VECTOR word to seed the PC
// FETCH_OP   | read opcode word at PC, pre-decode extension count
// FETCH_EXT1 | read first extension word
// FETCH_EXT2 | read second extension word (always destination)
// HOLD       | bundle presented until taken
module instruction_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFE
) (
    input  logic clk,
    input  logic rst,
    instruction_fetch_if.master bus
);
    typedef enum logic [2:0] {
        VECTOR,
        FETCH_OP,
        FETCH_EXT1,
        FETCH_EXT2,
        HOLD
    } state_t;

    localparam logic [15:0] VEC_ADDR = RESET_VECTOR & 16'hFFFE;

    state_t      state;
    logic [15:0] pc;
    logic        need_src;
    logic        need_dst;
    logic        op_src;
    logic        op_dst;
    logic [15:0] pc_inc;
    logic [15:0] load_pc;
    logic [15:0] vec_pc;

    // Indexed/symbolic/absolute (As=01, not the R3 constant generator) and
    // immediate (As=11 on PC) source modes carry an extension word.
    function automatic logic as_ext(input logic [1:0] as_mode, input logic [3:0] reg_n);
        return ((as_mode == 2'b01) && (reg_n != 4'd3)) ||
               ((as_mode == 2'b11) && (reg_n == 4'd0));
    endfunction

    always_comb begin
        op_src = 1'b0;
        op_dst = 1'b0;
        if (bus.mem_rdata[15:14] != 2'b00) begin
            op_src = as_ext(bus.mem_rdata[5:4], bus.mem_rdata[11:8]);
            op_dst = bus.mem_rdata[7];
        end else if (bus.mem_rdata[15:10] == 6'b000100) begin
            op_src = as_ext(bus.mem_rdata[5:4], bus.mem_rdata[3:0]);
        end
    end

    assign pc_inc  = pc + 16'd2;
    assign load_pc = bus.pc_new & 16'hFFFE;
    assign vec_pc  = bus.mem_rdata & 16'hFFFE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= VECTOR;
            pc               <= '0;
            need_src         <= 1'b0;
            need_dst         <= 1'b0;
            bus.mem_rd       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.bundle_valid <= 1'b0;
            bus.ir           <= '0;
            bus.src_ext      <= '0;
            bus.dst_ext      <= '0;
            bus.has_src_ext  <= 1'b0;
            bus.has_dst_ext  <= 1'b0;
            bus.inst_pc      <= '0;
            bus.next_pc      <= '0;
        end else if (bus.pc_load && (state != VECTOR)) begin
            state            <= FETCH_OP;
            pc               <= load_pc;
            bus.mem_rd       <= 1'b1;
            bus.mem_addr     <= load_pc;
            bus.bundle_valid <= 1'b0;
        end else begin
            case (state)
                VECTOR: begin
                    // The request is raised one cycle after reset releases.
                    if (!bus.mem_rd) begin
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= VEC_ADDR;
                    end else if (bus.mem_ready) begin
                        pc           <= vec_pc;
                        bus.mem_addr <= vec_pc;
                        state        <= FETCH_OP;
                    end
                end
                FETCH_OP: begin
                    if (bus.mem_ready) begin
                        bus.ir          <= bus.mem_rdata;
                        bus.inst_pc     <= pc;
                        pc              <= pc_inc;
                        bus.src_ext     <= '0;
                        bus.dst_ext     <= '0;
                        bus.has_src_ext <= 1'b0;
                        bus.has_dst_ext <= 1'b0;
                        need_src        <= op_src;
                        need_dst        <= op_dst;
                        if (op_src || op_dst) begin
                            state        <= FETCH_EXT1;
                            bus.mem_addr <= pc_inc;
                        end else begin
                            state            <= HOLD;
                            bus.mem_rd       <= 1'b0;
                            bus.bundle_valid <= 1'b1;
                            bus.next_pc      <= pc_inc;
                        end
                    end
                end
                FETCH_EXT1: begin
                    if (bus.mem_ready) begin
                        pc <= pc_inc;
                        if (need_src) begin
                            bus.src_ext     <= bus.mem_rdata;
                            bus.has_src_ext <= 1'b1;
                        end else begin
                            bus.dst_ext     <= bus.mem_rdata;
                            bus.has_dst_ext <= 1'b1;
                        end
                        if (need_src && need_dst) begin
                            state        <= FETCH_EXT2;
                            bus.mem_addr <= pc_inc;
                        end else begin
                            state            <= HOLD;
                            bus.mem_rd       <= 1'b0;
                            bus.bundle_valid <= 1'b1;
                            bus.next_pc      <= pc_inc;
                        end
                    end
                end
                FETCH_EXT2: begin
                    if (bus.mem_ready) begin
                        pc               <= pc_inc;
                        bus.dst_ext      <= bus.mem_rdata;
                        bus.has_dst_ext  <= 1'b1;
                        state            <= HOLD;
                        bus.mem_rd       <= 1'b0;
                        bus.bundle_valid <= 1'b1;
                        bus.next_pc      <= pc_inc;
                    end
                end
                HOLD: begin
                    if (bus.take) begin
                        state            <= FETCH_OP;
                        bus.mem_rd       <= 1'b1;
                        bus.mem_addr     <= pc;
                        bus.bundle_valid <= 1'b0;
                    end
                end
                default: state <= VECTOR;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a word-level model of the MSP430
// extension rules predicts each bundle; a monitor checks what the DUT presents.
module tb_instruction_fetch;
    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] src;
        logic [15:0] dst;
        logic        hs;
        logic        hd;
        logic [15:0] inst_pc;
        logic [15:0] next_pc;
    } bundle_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();
    instruction_fetch #(.RESET_VECTOR(16'hFFFE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [0:32767];
    bundle_t     exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] stall_addr = 16'h0001;
    int          stall_len  = 0;
    bit          rand_ready = 1'b0;

    function automatic bit as_rule(input int as_mode, input int r);
        return (as_mode == 1 && r != 3) || (as_mode == 3 && r == 0);
    endfunction

    // Expected bundle for the instruction starting at byte address pc.
    function automatic bundle_t model(input logic [15:0] pc);
        bundle_t b;
        int      w;
        int      p;
        bit      s;
        bit      d;
        w = int'(mem[pc[15:1]]);
        s = 1'b0;
        d = 1'b0;
        if (w / 4096 >= 4) begin
            s = as_rule((w / 16) % 4, (w / 256) % 16);
            d = ((w / 128) % 2) == 1;
        end else if (w / 1024 == 4) begin
            s = as_rule((w / 16) % 4, w % 16);
        end
        b.ir      = 16'(w);
        b.inst_pc = pc;
        b.src     = '0;
        b.dst     = '0;
        b.hs      = s;
        b.hd      = d;
        p = (int'(pc) + 2) % 65536;
        if (s) begin
            b.src = mem[p / 2];
            p = (p + 2) % 65536;
        end
        if (d) begin
            b.dst = mem[p / 2];
            p = (p + 2) % 65536;
        end
        b.next_pc = 16'(p);
        return b;
    endfunction

    task automatic push_stream(input logic [15:0] start, input int k);
        logic [15:0] pc;
        bundle_t     b;
        pc = start;
        for (int i = 0; i < k; i++) begin
            b = model(pc);
            exp_q.push_back(b);
            pc = b.next_pc;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mem[a[15:1]] = d;
    endtask

    task automatic tick();
        @(negedge clk);
        bus.take = ($urandom_range(0, 2) != 0) && (exp_q.size() > 0);
    endtask

    task automatic do_reset(input logic [15:0] vec, input int k);
        logic [47:0] outs;
        tick();
        rst         = 1'b1;
        bus.pc_load = 1'b0;
        exp_q.delete();
        wr(16'hFFFE, vec);
        tick();
        outs = {bus.mem_rd, bus.mem_addr[14:0], bus.bundle_valid, bus.ir[14:0],
                bus.has_src_ext, bus.has_dst_ext, bus.src_ext[13:0]};
        checks++;
        if (outs != '0 || bus.mem_addr != 0 || bus.ir != 0 || bus.src_ext != 0 ||
            bus.dst_ext != 0 || bus.inst_pc != 0 || bus.next_pc != 0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b addr=%h bv=%b ir=%h src=%h dst=%h hs=%b hd=%b ipc=%h npc=%h, required all 0",
                     bus.mem_rd, bus.mem_addr, bus.bundle_valid, bus.ir, bus.src_ext, bus.dst_ext,
                     bus.has_src_ext, bus.has_dst_ext, bus.inst_pc, bus.next_pc);
        end
        rst = 1'b0;
        push_stream(vec & 16'hFFFE, k);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            tick();
            i++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d bundles outstanding after %0d cycles, required 0", name, exp_q.size(), i);
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic redirect(input logic [15:0] tgt, input int k);
        tick();
        bus.pc_load = 1'b1;
        bus.pc_new  = tgt;
        exp_q.delete();
        push_stream(tgt & 16'hFFFE, k);
        tick();
        bus.pc_load = 1'b0;
    endtask

    // Memory: returns the addressed word whenever it signals ready.
    initial begin : responder
        int stall_cnt;
        stall_cnt     = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_addr != stall_addr) stall_cnt = 0;
            if (bus.mem_rd && bus.mem_addr == stall_addr && stall_cnt < stall_len) begin
                bus.mem_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus.mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            bus.mem_rdata = bus.mem_ready ? mem[bus.mem_addr[15:1]] : 16'($urandom);
        end
    end

    initial begin : monitor
        bundle_t     e;
        bit          e_ok;
        bit          seen;
        bit          vec_pending;
        int          cnt;
        logic        rs, pl, xfer, rd_b, rdy_b;
        logic [15:0] addr_b;
        seen        = 1'b0;
        e_ok        = 1'b0;
        vec_pending = 1'b1;
        cnt         = 0;
        e           = '0;
        forever begin
            @(posedge clk);
            rs     = rst;
            pl     = bus.pc_load;
            rd_b   = bus.mem_rd;
            rdy_b  = bus.mem_ready;
            addr_b = bus.mem_addr;
            xfer   = rd_b && rdy_b;
            if (rs) begin
                cnt         = 0;
                vec_pending = 1'b1;
            end else if (pl) begin
                cnt = 0;
            end else if (xfer) begin
                if (vec_pending) begin
                    vec_pending = 1'b0;
                    checks++;
                    if (addr_b != 16'hFFFE) begin
                        errors++;
                        $display("FAIL vector_addr: read at %h, required fffe", addr_b);
                    end
                end else begin
                    cnt++;
                end
            end
            #1;
            if (rs) begin
                seen = 1'b0;
                continue;
            end
            if (rd_b && !rdy_b && !pl) begin
                checks++;
                if (!bus.mem_rd || bus.mem_addr != addr_b) begin
                    errors++;
                    $display("FAIL stall_hold: rd=%b addr=%h, required rd=1 addr=%h", bus.mem_rd, bus.mem_addr, addr_b);
                end
            end
            if (bus.bundle_valid && !seen) begin
                seen = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    e_ok = 1'b0;
                    $display("FAIL unexpected_bundle: ir=%h inst_pc=%h presented, none expected", bus.ir, bus.inst_pc);
                end else begin
                    e    = exp_q.pop_front();
                    e_ok = 1'b1;
                    if (bus.ir != e.ir || bus.src_ext != e.src || bus.dst_ext != e.dst ||
                        bus.has_src_ext != e.hs || bus.has_dst_ext != e.hd ||
                        bus.inst_pc != e.inst_pc || bus.next_pc != e.next_pc) begin
                        errors++;
                        $display("FAIL bundle: got ir=%h src=%h dst=%h hs=%b hd=%b ipc=%h npc=%h, required ir=%h src=%h dst=%h hs=%b hd=%b ipc=%h npc=%h",
                                 bus.ir, bus.src_ext, bus.dst_ext, bus.has_src_ext, bus.has_dst_ext, bus.inst_pc, bus.next_pc,
                                 e.ir, e.src, e.dst, e.hs, e.hd, e.inst_pc, e.next_pc);
                    end
                    checks++;
                    if (!xfer || pl || cnt != 1 + int'(e.hs) + int'(e.hd)) begin
                        errors++;
                        $display("FAIL word_count: %0d reads, last-read-this-edge=%b, required %0d reads ending this edge",
                                 cnt, xfer, 1 + int'(e.hs) + int'(e.hd));
                    end
                end
                cnt = 0;
            end else if (bus.bundle_valid) begin
                if (e_ok) begin
                    checks++;
                    if (bus.ir != e.ir || bus.src_ext != e.src || bus.dst_ext != e.dst ||
                        bus.inst_pc != e.inst_pc || bus.next_pc != e.next_pc) begin
                        errors++;
                        $display("FAIL bundle_stable: ir=%h ipc=%h npc=%h, required ir=%h ipc=%h npc=%h",
                                 bus.ir, bus.inst_pc, bus.next_pc, e.ir, e.inst_pc, e.next_pc);
                    end
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int i;
        bus.pc_load = 1'b0;
        bus.pc_new  = '0;
        bus.take    = 1'b0;
        for (int a = 0; a < 32768; a++) mem[a] = 16'($urandom);
        wr(16'hC000, 16'h40B2); wr(16'hC002, 16'h1234); wr(16'hC004, 16'h0200);
        wr(16'hC006, 16'h3C00); wr(16'hC008, 16'h4315);
        wr(16'hC00A, 16'h1214); wr(16'hC00C, 16'h0002);
        wr(16'hD000, 16'h4315);

        do_reset(16'hC000, 4);
        drain("program");

        do_reset(16'hC001, 1);
        drain("odd_vector");

        stall_addr = 16'hC002;
        stall_len  = 3;
        do_reset(16'hC000, 1);
        drain("ext_stall");

        stall_len = 6;
        do_reset(16'hC000, 1);
        i = 0;
        while (!(bus.mem_rd && bus.mem_addr == 16'hC002) && i < 50) begin
            tick();
            i++;
        end
        checks++;
        if (i >= 50) begin
            errors++;
            $display("FAIL reach_ext1: mem_addr=%h, required c002 within 50 cycles", bus.mem_addr);
        end
        bus.pc_load = 1'b1;
        bus.pc_new  = 16'hD001;
        exp_q.delete();
        push_stream(16'hD000, 1);
        tick();
        bus.pc_load = 1'b0;
        checks++;
        if (bus.mem_addr != 16'hD000 || bus.bundle_valid) begin
            errors++;
            $display("FAIL redirect_ext1: addr=%h bv=%b, required addr=d000 bv=0", bus.mem_addr, bus.bundle_valid);
        end
        stall_addr = 16'h0001;
        stall_len  = 0;
        drain("redirect_ext1");

        tick();
        bus.pc_load = 1'b1;
        bus.pc_new  = 16'hC006;
        bus.take    = 1'b1;
        exp_q.delete();
        push_stream(16'hC006, 1);
        tick();
        bus.pc_load = 1'b0;
        checks++;
        if (bus.mem_addr != 16'hC006 || bus.bundle_valid) begin
            errors++;
            $display("FAIL redirect_vs_take: addr=%h bv=%b, required addr=c006 bv=0", bus.mem_addr, bus.bundle_valid);
        end
        drain("redirect_vs_take");

        wr(16'hFFFC, 16'h4584);
        redirect(16'hFFFC, 1);
        drain("wrap");

        do_reset(16'hC000, 2);
        drain("reset_in_hold");

        rand_ready = 1'b1;
        for (int s = 0; s < 40; s++) begin
            logic [15:0] tgt;
            int          k;
            tgt = 16'($urandom);
            k   = $urandom_range(1, 6);
            if (s % 10 == 9) begin
                do_reset(tgt, k);
                drain("random_reset");
            end else begin
                redirect(tgt, k);
                if ($urandom_range(0, 1) == 1) drain("random_stream");
                else repeat ($urandom_range(1, 15)) tick();
            end
        end
        redirect(16'hC000, 3);
        drain("final_stream");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
